// File: rtl/hist_pkg.sv
// Shared constants for the histogram CDF reader: geometry of the scratch histogram and FSM encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hist_pkg;

    localparam int NUM_BINS      = 256;
    localparam int BIN_W         = 32;
    localparam int BINS_PER_WORD = 4;
    localparam int WORD_W        = BIN_W * BINS_PER_WORD;
    localparam int HIST_WORDS    = NUM_BINS / BINS_PER_WORD;

    // Reader FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/hist_word_fifo.sv
// Two-entry first-word-fall-through FIFO holding scratch words; count feeds read-credit tracking.
// Latency: 0 cycles when empty (push data appears on head the same cycle), otherwise head is the oldest entry.
// Backpressure: none internally; the producer must never push when full (guaranteed by the reader's credit rule).
module hist_word_fifo
    import hist_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             store;
    logic             take;

    // A push that is consumed straight through an empty FIFO is never stored
    assign store    = push & ~((count == 2'd0) & pop);
    assign take     = pop & (count != 2'd0);
    assign head_vld = (count != 2'd0) | push;
    assign head_dat = (count != 2'd0) ? mem[rd_ptr] : push_dat;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) wr_ptr <= ~wr_ptr;
            if (take)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(store) - 2'(take);
        end
    end

    // Data storage needs no reset; occupancy qualifies it
    always_ff @(posedge clock) begin
        if (store) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/hist_cdf_reader.sv
// Reads the packed scratch histogram, unpacks bins and streams a saturating running CDF, one value per bin.
// Latency: first cdf_valid 1 + MEM_RD_LAT + 1 cycles after start; 1 bin/cycle when cdf_ready stays high.
// Backpressure: cdf_ready stalls the output register; reads are credit-limited to 2 words so nothing is lost.
// Optional build macro HIST_RD_CLEAR_EN adds a write port that zeroes each scratch word once consumed.
module hist_cdf_reader
    import hist_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int BIN_W         = hist_pkg::BIN_W,
    parameter int BINS_PER_WORD = hist_pkg::BINS_PER_WORD,
    parameter int NUM_BINS      = hist_pkg::NUM_BINS,
    parameter int BASE_ADDR     = 0,
    parameter int MEM_RD_LAT    = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    output logic                           read_enable,
    output logic [ADDR_W-1:0]              read_address,
    input  logic [BIN_W*BINS_PER_WORD-1:0] rdata,
    output logic                           cdf_valid,
    input  logic                           cdf_ready,
    output logic [7:0]                     cdf_bin,
    output logic [BIN_W-1:0]               cdf_value,
    output logic                           cdf_last,
    output logic                           busy,
    output logic                           done
`ifdef HIST_RD_CLEAR_EN
    ,
    output logic                           write_enable,
    output logic [ADDR_W-1:0]              write_address,
    output logic [BIN_W*BINS_PER_WORD-1:0] wdata
`endif
);

    localparam int                WORD_BITS = BIN_W * BINS_PER_WORD;
    localparam int                N_WORDS   = NUM_BINS / BINS_PER_WORD;
    localparam int                LANE_W    = (BINS_PER_WORD > 1) ? $clog2(BINS_PER_WORD) : 1;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);
    localparam logic [7:0]        LAST_BIN  = 8'(NUM_BINS - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BINS_PER_WORD - 1);

    logic [1:0]            state;
    logic                  start_go;
    logic [ADDR_W-1:0]     word_cnt;
    logic [ADDR_W-1:0]     addr_q;
    logic [MEM_RD_LAT-1:0] rd_pipe;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  load;
    logic                  hs;
    logic [1:0]            fifo_cnt;
    logic                  head_vld;
    logic [WORD_BITS-1:0]  head_dat;
    logic [LANE_W-1:0]     lane;
    logic [7:0]            bin_cnt;
    logic [BIN_W-1:0]      acc;
    logic [BIN_W-1:0]      acc_eff;
    logic [BIN_W-1:0]      bin_sel;
    logic [BIN_W:0]        sum_wide;
    logic [BIN_W-1:0]      sum_sat;
    logic                  out_vld;
    logic                  out_last;
    logic [7:0]            out_bin;
    logic [BIN_W-1:0]      out_val;

    assign start_go = (state == ST_IDLE) & start;
    // Words in flight plus words buffered never exceed the FIFO depth
    assign issue    = (state == ST_READ) && (($countones(rd_pipe) + int'(fifo_cnt)) < 2);
    assign push     = rd_pipe[MEM_RD_LAT-1];
    assign hs       = out_vld & cdf_ready;
    assign load     = head_vld & (~out_vld | cdf_ready);
    assign pop      = load & (lane == LAST_LANE);
    assign bin_sel  = head_dat[lane*BIN_W +: BIN_W];
    // The value being accepted this cycle is already part of the running sum
    assign acc_eff  = hs ? out_val : acc;
    assign sum_wide = {1'b0, acc_eff} + {1'b0, bin_sel};
    assign sum_sat  = sum_wide[BIN_W] ? {BIN_W{1'b1}} : sum_wide[BIN_W-1:0];

    hist_word_fifo #(.WIDTH(WORD_BITS)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (rdata),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    // Pass sequencing: issue all reads, wait for the last bin to drain, pulse done
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state <= ST_READ;
                ST_READ:  if (issue && (word_cnt == LAST_WORD)) state <= ST_DRAIN;
                ST_DRAIN: if (hs && out_last) state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Read address generation and in-flight tracking; a reset empties the pipe so late data is ignored
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_cnt <= '0;
            addr_q   <= '0;
            rd_pipe  <= '0;
        end else begin
            rd_pipe <= (rd_pipe << 1) | MEM_RD_LAT'(issue);
            if (start_go) begin
                word_cnt <= '0;
            end else if (issue) begin
                word_cnt <= word_cnt + ADDR_W'(1);
                addr_q   <= BASE + word_cnt;
            end
        end
    end

    // Lane unpack, output register and accumulator
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            lane     <= '0;
            bin_cnt  <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_bin  <= '0;
            out_val  <= '0;
        end else if (start_go) begin
            acc     <= '0;
            lane    <= '0;
            bin_cnt <= '0;
            out_vld <= 1'b0;
        end else begin
            if (hs) acc <= out_val;
            if (load) begin
                out_vld  <= 1'b1;
                out_val  <= sum_sat;
                out_bin  <= bin_cnt;
                out_last <= (bin_cnt == LAST_BIN);
                bin_cnt  <= bin_cnt + 8'd1;
                lane     <= (lane == LAST_LANE) ? '0 : lane + LANE_W'(1);
            end else if (hs) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign read_enable  = issue;
    assign read_address = issue ? (BASE + word_cnt) : addr_q;
    assign cdf_valid    = out_vld;
    assign cdf_bin      = out_bin;
    assign cdf_value    = out_val;
    assign cdf_last     = out_last;
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);

`ifdef HIST_RD_CLEAR_EN
    logic [ADDR_W-1:0] pop_cnt;

    // Zero each scratch word the cycle after its last lane leaves the FIFO
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pop_cnt       <= '0;
            write_enable  <= 1'b0;
            write_address <= '0;
        end else begin
            write_enable <= pop;
            if (start_go) begin
                pop_cnt <= '0;
            end else if (pop) begin
                pop_cnt       <= pop_cnt + ADDR_W'(1);
                write_address <= BASE + pop_cnt;
            end
        end
    end

    assign wdata = '0;
`endif

endmodule

// File: doc/hist_cdf_reader.md
Name: hist_cdf_reader

Overview:
- Reads the 256-bin histogram that the histogram data path wrote to scratch memory as 128-bit words, each holding four 32-bit bins.
- Unpacks each word into bins and accumulates a running cumulative distribution (CDF).
- Streams one CDF value per bin to the equalizer mapping stage over a valid/ready interface.
- Sits in histogram_equalizer_core between the scratch memory read port and the mapping logic.

Parameters:
- ADDR_W, 16, scratch memory address width
- BIN_W, 32, width of one histogram bin and of the CDF value
- BINS_PER_WORD, 4, bins packed per scratch word (word width = BIN_W*BINS_PER_WORD)
- NUM_BINS, 256, total bins; must be a multiple of BINS_PER_WORD
- BASE_ADDR, 0, scratch address of the word holding bins 0..3
- MEM_RD_LAT, 1, cycles from read_enable to valid rdata (1..3)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a pass
- read_enable  out  1  scratch read strobe
- read_address  out  ADDR_W  scratch read address
- rdata  in  BIN_W*BINS_PER_WORD  scratch read data; bin 4k+0 is in [31:0], bin 4k+3 is in [127:96]
- cdf_valid  out  1  CDF output valid
- cdf_ready  in  1  downstream accepts
- cdf_bin  out  8  bin index of the current output
- cdf_value  out  BIN_W  cumulative count through cdf_bin
- cdf_last  out  1  high with bin NUM_BINS-1
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse after the last bin is accepted
- write_enable, write_address, wdata  out  1/ADDR_W/128  clear port; exists only when HIST_RD_CLEAR_EN is defined

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, accumulator 0, buffer empty.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ on start. Accumulator and word counter clear in the same cycle.
  - READ: issues one read per cycle when (reads in flight + buffered words) < 2. Addresses run BASE_ADDR+0 .. BASE_ADDR+NUM_BINS/BINS_PER_WORD-1 (64 words). Moves to DRAIN after the last read is issued.
  - DRAIN: waits until the last bin is accepted, then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Returning rdata is captured into a 2-entry word FIFO at issue+MEM_RD_LAT. The credit rule means the FIFO never overflows, whatever cdf_ready does.
- Lane unpack: a lane counter 0..3 selects a bin from the FIFO head. The word pops when lane 3 is accepted.
- Output register:
  - cdf_value = accumulator + selected bin, computed when the output register loads.
  - The accumulator updates to that sum on handshake (cdf_valid & cdf_ready).
  - cdf_valid holds and cdf_bin/cdf_value stay stable until the handshake.
- Latency: first cdf_valid appears at start + 1 + MEM_RD_LAT + 1 cycles. With cdf_ready tied high, throughput is 1 bin/cycle.
- Arithmetic: unsigned, saturating at 2^BIN_W-1. There is no wrap.
- cdf_bin counts 0..255; cdf_last is asserted only at bin 255.
- busy = 1 from the cycle after start through the DONE cycle.
- start while busy is ignored.
- All-zero histogram: 256 outputs, all with value 0.
- Reset mid-pass: everything aborts immediately. In-flight read data arriving after release is dropped, because no reads are outstanding in IDLE.
- read_address holds its last value when read_enable=0.

Optional Feature:
HIST_RD_CLEAR_EN
- Defined:
  - When the last lane of a word is popped, the block drives write_enable=1, write_address = that word's address and wdata = 0 for one cycle.
  - This clears the scratch histogram for the next image.
  - The clear port has no backpressure.
- Undefined: the write port is absent and scratch memory is left untouched.

Decomposition:
- Shared package/header (hist_pkg) holds NUM_BINS, BIN_W, BINS_PER_WORD, WORD_W, HIST_WORDS = NUM_BINS/BINS_PER_WORD, and the FSM state encodings.
- One natural sub-module: hist_word_fifo, the 2-entry 128-bit FIFO with push/pop/count used for read-credit tracking.

Test Plan:
1. Every bin = 1, cdf_ready=1 -> cdf_value for bin k = k+1. Bin 255 gives 256 with cdf_last=1. done pulses one cycle later. 64 reads issued at addresses 0..63.
2. Bin k = k, random cdf_ready at 30% -> values match k(k+1)/2, no bins are lost or duplicated, and outputs stay stable while stalled.
3. Bins 0..3 = 0xFFFF_FFF0 -> bin 0 = 0xFFFF_FFF0, and bins 1..255 saturate at 0xFFFF_FFFF.
4. A second start at bin 100, MEM_RD_LAT=3 -> it is ignored. The sequence completes normally and first cdf_valid arrives 5 cycles after start.
5. reset asserted at bin 37, then start re-issued -> outputs go 0 immediately. The new pass restarts at bin 0 with a CDF from 0.
6. HIST_RD_CLEAR_EN defined -> 64 zero writes, each following its read. A second pass returns all zeros.
